pwm_ramp_ctrl: RTL and testbench

Sequencing controller for the PWM datapath in `top`. It owns the PWM period counter and the active duty register. It accepts new duty targets over a valid/ready handshake and walks the active duty toward each target by a fixed step per PWM period. All duty changes land on period boundaries, so the PWM waveform never glitches mid-period.

---
 rtl/pwm_ramp_ctrl.sv | 148 ++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: PWM period counter + duty register, ramped toward
// handshaked duty targets. Duty changes only on period boundaries.
//
// Ports:
//   CLK, nRST       clock, async active-low reset
//   enable          run control (0: cnt=0, pwm low, FSM frozen)
//   period          terminal count, period is period+1 cycles
//   req_valid/ready duty target handshake, req_duty the target
//   pwm_out         registered PWM output
//   cnt, duty_cur   live counter and applied duty
//   busy, done      ramp in progress / one-cycle completion pulse
//
// Build option: PWM_RAMP_CTRL_RAMP_EN
//   defined   -> duty walks by STEP per boundary
//   undefined -> duty jumps to target at first boundary
module pwm_ramp_ctrl #(
  parameter int CNT_W = 8,
  parameter int STEP  = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_duty,
  output logic             req_ready,
  output logic             pwm_out,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] duty_cur,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

`ifdef PWM_RAMP_CTRL_RAMP_EN
  localparam logic [CNT_W-1:0] STEP_V = CNT_W'(STEP);
`else
  // Full-scale step: any distance closes in a single boundary.
  localparam logic [CNT_W-1:0] STEP_V =
    CNT_W'(STEP) | {CNT_W{1'b1}};
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic             pwm_q, pwm_d;
  logic             done_q, done_d;

  logic             bnd;
  logic             tick;
  logic             acc;
  logic             up;
  logic [CNT_W-1:0] diff;
  logic             close;

  // >= so a period lowered below cnt wraps on the next edge.
  assign bnd  = cnt_q >= period;
  assign tick = enable && bnd;
  assign acc  = req_valid && req_ready;

  // Distance taken in the safe direction, so no wrap and
  // the clamp decision precedes any subtraction.
  assign up    = tgt_q >= duty_q;
  assign diff  = up ? (tgt_q - duty_q) : (duty_q - tgt_q);
  assign close = diff <= STEP_V;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (acc && (req_duty != duty_q)) state_d = RAMP;
      end
      (state_q == RAMP): begin
        if (tick && close) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    // The FSM is frozen while disabled, so no acceptance then.
    req_ready = (state_q == IDLE) && enable;
    busy      = (state_q == RAMP);
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!enable || bnd) cnt_d = '0;
    pwm_d  = enable && (cnt_q < duty_q);
    duty_d = duty_q;
    tgt_d  = tgt_q;
    done_d = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (acc) begin
          tgt_d  = req_duty;
          done_d = (req_duty == duty_q);
        end
      end
      (state_q == RAMP): begin
        if (tick) begin
          if (close) begin
            duty_d = tgt_q;
            done_d = 1'b1;
          end else if (up) begin
            duty_d = duty_q + STEP_V;
          end else begin
            duty_d = duty_q - STEP_V;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q  <= '0;
      duty_q <= '0;
      tgt_q  <= '0;
      pwm_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      tgt_q  <= tgt_d;
      pwm_q  <= pwm_d;
      done_q <= done_d;
    end
  end

  assign cnt      = cnt_q;
  assign duty_cur = duty_q;
  assign pwm_out  = pwm_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed checks of pwm_ramp_ctrl with
// STEP=1 (u_s1) and STEP=4 (u_s4) instances.
module tb_pwm_ramp_ctrl;

`ifdef PWM_RAMP_CTRL_RAMP_EN
  localparam bit RE = 1'b1;
`else
  localparam bit RE = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            nrst;
  logic            en;
  logic [7:0]      period;
  logic [1:0]      req_valid;
  logic [1:0][7:0] req_duty;
  logic [1:0]      rdy;
  logic [1:0]      pwm;
  logic [1:0][7:0] cnt;
  logic [1:0][7:0] duty;
  logic [1:0]      busy;
  logic [1:0]      done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.CNT_W(8), .STEP(1)) u_s1 (
    .CLK(clk), .nRST(nrst), .enable(en),
    .period(period),
    .req_valid(req_valid[0]), .req_duty(req_duty[0]),
    .req_ready(rdy[0]), .pwm_out(pwm[0]),
    .cnt(cnt[0]), .duty_cur(duty[0]),
    .busy(busy[0]), .done(done[0])
  );

  pwm_ramp_ctrl #(.CNT_W(8), .STEP(4)) u_s4 (
    .CLK(clk), .nRST(nrst), .enable(en),
    .period(period),
    .req_valid(req_valid[1]), .req_duty(req_duty[1]),
    .req_ready(rdy[1]), .pwm_out(pwm[1]),
    .cnt(cnt[1]), .duty_cur(duty[1]),
    .busy(busy[1]), .done(done[1])
  );

  task automatic check(input string tag, input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, act, exp);
    end
  endtask

  task automatic count_high(input int idx, input int n,
                            output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pwm[idx]) h++;
    end
  endtask

  // Issue one target, record every duty change until done.
  task automatic ramp(input int idx, input logic [7:0] tgt,
                      input int n, input logic [7:0][7:0] ev,
                      input string tag);
    logic [7:0] prev;
    int got, dones, k, ok;
    @(posedge clk); #1;
    req_valid[idx] = 1'b1;
    req_duty[idx]  = tgt;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy[idx]) begin
        ok = 1;
        break;
      end
    end
    check({tag, "_acc"}, ok, 1);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    prev  = duty[idx];
    got   = 0;
    dones = 0;
    k     = 0;
    for (int i = 0; i < 3000 && k < 4; i++) begin
      @(negedge clk);
      if (duty[idx] != prev) begin
        if (got < 8) check({tag, "_step"}, duty[idx], ev[got]);
        check({tag, "_at_cnt0"}, cnt[idx], 0);
        got++;
        prev = duty[idx];
      end
      if (done[idx]) dones++;
      if (dones > 0) k++;
    end
    check({tag, "_nsteps"}, got, n);
    check({tag, "_done1"}, dones, 1);
    check({tag, "_idle"}, busy[idx], 0);
    check({tag, "_final"}, duty[idx], tgt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int h, ok;
    nrst      = 1'b0;
    en        = 1'b1;
    period    = 8'd9;
    req_valid = '0;
    req_duty  = '0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_cnt", cnt[0], 0);
      check("rst_pwm", pwm[0], 0);
      check("rst_rdy", rdy[0], 1);
      check("rst_busy", busy[0], 0);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("cnt_seq", cnt[0], i % 10);
    end

    // Lowering period below cnt wraps on the next edge.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (cnt[0] == 8'd7) break;
    end
    period = 8'd3;
    @(posedge clk); #1;
    check("cnt_wrap_low", cnt[0], 0);
    period = 8'd9;

    ramp(0, 8'd3, RE ? 3 : 1,
         RE ? 64'({8'd3, 8'd2, 8'd1}) : 64'(8'd3), "up");
    repeat (20) @(negedge clk);
    count_high(0, 10, h);
    check("up_duty3_of10", h, 3);

    ramp(1, 8'd10, RE ? 3 : 1,
         RE ? 64'({8'd10, 8'd8, 8'd4}) : 64'(8'd10), "s4_up");
    ramp(1, 8'd1, RE ? 3 : 1,
         RE ? 64'({8'd1, 8'd2, 8'd6}) : 64'(8'd1), "s4_dn");
    ramp(1, 8'd1, 0, 64'(0), "s4_eq");

    // Held request during a ramp is taken only in the done cycle.
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_duty[0]  = 8'd8;
    @(negedge clk);
    check("hs_rdy_idle", rdy[0], 1);
    @(posedge clk); #1;
    req_duty[0] = 8'd5;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done[0]) begin
        ok = 1;
        break;
      end
      check("hs_rdy_low", rdy[0], 0);
    end
    check("hs_done_first", ok, 1);
    check("hs_duty_first", duty[0], 8);
    check("hs_rdy_done", rdy[0], 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("hs_busy_again", busy[0], 1);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done[0]) begin
        ok = 1;
        break;
      end
    end
    check("hs_done_second", ok, 1);
    check("hs_duty_second", duty[0], 5);

    ramp(0, 8'd0, RE ? 5 : 1,
         RE ? 64'({8'd0, 8'd1, 8'd2, 8'd3, 8'd4}) : 64'(8'd0),
         "zero");
    count_high(0, 20, h);
    check("zero_pwm_low", h, 0);

    ramp(0, 8'd200, RE ? 200 : 1,
         RE ? 64'({8'd8, 8'd7, 8'd6, 8'd5,
                   8'd4, 8'd3, 8'd2, 8'd1}) : 64'(8'd200),
         "big");
    count_high(0, 20, h);
    check("big_pwm_high", h, 20);

    // Reset mid-ramp on the STEP=4 instance.
    @(posedge clk); #1;
    req_valid[1] = 1'b1;
    req_duty[1]  = 8'd100;
    @(negedge clk);
    check("ab_rdy", rdy[1], 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (duty[1] != 8'd1) begin
        ok = 1;
        break;
      end
    end
    check("ab_moved", ok, 1);
    repeat (3) @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("ab_cnt", cnt[1], 0);
    check("ab_duty", duty[1], 0);
    check("ab_pwm", pwm[1], 0);
    check("ab_busy", busy[1], 0);
    check("ab_done", done[1], 0);
    check("ab_rdy_rst", rdy[1], 1);
    @(posedge clk); #1;
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    check("ab_duty_after", duty[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
